ds_burst_gate: RTL



---
 rtl/ds_pkg.sv | 31 +++
 rtl/cm_if_lvl.sv | 12 +
 rtl/ds_if.sv | 11 +
 rtl/ds_burst_tmr.sv | 35 +++
 rtl/ds_burst_gate.sv | 126 ++++++++++++
 5 files changed

// File: rtl/ds_pkg.sv
// Shared types and helpers for the ds_* stream blocks.
package ds_pkg;

  // Burst gate states: waiting for a burst to be available, or passing one.
  typedef enum logic [0:0] {
    BG_IDLE  = 1'b0,
    BG_BURST = 1'b1
  } t_burst_st;

  // Ceiling log2; sclog2(1) = 0, sclog2(9) = 4, sclog2(65) = 7.
  function automatic int sclog2(input int val);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < val) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = sclog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cm_if_lvl.sv
// Occupancy level interface: producer reports level and a threshold compare,
// consumer supplies the threshold.
interface cm_if_lvl #(
  parameter int LVL_W = 5
) ();
  logic [LVL_W-1:0] lvl;
  logic             lvl_gte;
  logic [LVL_W-1:0] lvl_thr;

  modport mst (output lvl, output lvl_gte, input lvl_thr);
  modport slv (input lvl, input lvl_gte, output lvl_thr);
endinterface

// File: rtl/ds_if.sv
// Valid/ready stream interface carrying one beat of DTYPE per transfer.
interface ds_if #(
  parameter type DTYPE = logic [7:0]
) ();
  DTYPE data;
  logic vld;
  logic rdy;

  modport mst (output data, output vld, input rdy);
  modport slv (input data, input vld, output rdy);
endinterface

// File: rtl/ds_burst_tmr.sv
// Saturating idle counter: clear has priority, counts up on enable and
// stops at MAX; done flags that the limit has been reached.
module ds_burst_tmr
  import ds_pkg::*;
#(
  parameter int MAX = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int               CNT_W = cnt_width(MAX);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear, saturating increment, or hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_en && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_done = (cnt_r == MAX_C);

endmodule

// File: rtl/ds_burst_gate.sv
// Burst-forming gate behind ds_fifo: holds traffic until a full burst is
// buffered (or a partial one has waited TIMEOUT cycles), then passes exactly
// that many beats, marking the final one and reporting the length up front.
module ds_burst_gate
  import ds_pkg::*;
#(
  parameter int  BURST_LEN = 16,
  parameter int  TIMEOUT   = 64,
  parameter int  LVL_W     = 5,
  parameter type DTYPE     = logic [7:0]
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ds_if.slv                if_in,
  cm_if_lvl.slv            if_in_lvl,
  ds_if.mst                if_out,
  output logic             o_last,
  output logic [LVL_W-1:0] o_len
);

  localparam logic [LVL_W-1:0] BURST_LEN_C = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] ZERO_C      = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] ONE_C       = LVL_W'(1);
  localparam bit               FLUSH_EN    = (TIMEOUT != 0);

  t_burst_st        state_r;
  t_burst_st        state_nxt_s;
  logic [LVL_W-1:0] cnt_r;
  logic [LVL_W-1:0] cnt_nxt_s;
  logic [LVL_W-1:0] len_r;
  logic [LVL_W-1:0] len_nxt_s;
  logic [LVL_W-1:0] part_len_s;
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmr_done_s;
  logic             flush_s;
  logic             out_vld_s;
  logic             in_rdy_s;
  logic             xfer_s;
  logic             last_s;
  DTYPE             data_s;

  // The timer only runs while idle with something buffered; holding it clear
  // during a burst means it restarts from zero on every return to idle.
  assign tmr_clr_s = (state_r != BG_IDLE) || (if_in_lvl.lvl == ZERO_C);
  assign tmr_en_s  = 1'b1;

  ds_burst_tmr #(
    .MAX (TIMEOUT)
  ) u_tmr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (tmr_clr_s),
    .i_en    (tmr_en_s),
    .o_done  (tmr_done_s)
  );

  // Partial-burst length is clamped because lvl_gte lags lvl by a cycle and
  // the level may already have crossed BURST_LEN when the timeout fires.
  assign part_len_s = (if_in_lvl.lvl < BURST_LEN_C) ? if_in_lvl.lvl : BURST_LEN_C;
  assign flush_s    = FLUSH_EN && tmr_done_s && (if_in_lvl.lvl != ZERO_C);

  // Next-state, burst counter and stream handshake decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    len_nxt_s   = len_r;
    out_vld_s   = 1'b0;
    in_rdy_s    = 1'b0;
    xfer_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      BG_IDLE: begin
        if (if_in_lvl.lvl_gte) begin
          state_nxt_s = BG_BURST;
          cnt_nxt_s   = BURST_LEN_C;
          len_nxt_s   = BURST_LEN_C;
        end else if (flush_s) begin
          state_nxt_s = BG_BURST;
          cnt_nxt_s   = part_len_s;
          len_nxt_s   = part_len_s;
        end else begin
          state_nxt_s = BG_IDLE;
        end
      end
      BG_BURST: begin
        out_vld_s = if_in.vld;
        in_rdy_s  = if_out.rdy;
        xfer_s    = if_in.vld && if_out.rdy;
        last_s    = (cnt_r == ONE_C);
        if (xfer_s) begin
          cnt_nxt_s   = cnt_r - ONE_C;
          state_nxt_s = (cnt_r == ONE_C) ? BG_IDLE : BG_BURST;
        end else begin
          state_nxt_s = BG_BURST;
        end
      end
      default: begin
        state_nxt_s = BG_IDLE;
        cnt_nxt_s   = ZERO_C;
      end
    endcase
  end

  // State, remaining-beat count and reported burst length
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= BG_IDLE;
      cnt_r   <= ZERO_C;
      len_r   <= ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      len_r   <= len_nxt_s;
    end
  end

  assign data_s            = if_in.data;
  assign if_out.data       = data_s;
  assign if_out.vld        = out_vld_s;
  assign if_in.rdy         = in_rdy_s;
  assign if_in_lvl.lvl_thr = BURST_LEN_C;
  assign o_last            = last_s;
  assign o_len             = len_r;

endmodule
